// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared data RAM: serialises port A (CU/datapath) and
// port B (loader/debug) accesses through an IDLE -> ACC -> ACK sequence.
module mem_port_arbiter #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [1:0]        a_op,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_stall,
    input  logic              b_req,
    input  logic [1:0]        b_op,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_push,
    output logic              mem_pop,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] ACC  = 2'b01;
    localparam logic [1:0] ACK  = 2'b10;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_PUSH  = 2'b10;
    localparam logic [1:0] OP_POP   = 2'b11;

    logic [1:0]        state;
    logic [1:0]        op_lat;
    logic              sel;         // 0 = port A owns the access, 1 = port B
    logic              last_grant;  // same encoding as sel
    logic              grant_a;
    logic              grant_b;
    logic [1:0]        g_op;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    // On a tie, round-robin hands the port to whoever did not win last time.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_req && b_req) begin
            if (PRIO_MODE != 0 || last_grant) begin
                grant_a = 1'b1;
            end else begin
                grant_b = 1'b1;
            end
        end else if (a_req) begin
            grant_a = 1'b1;
        end else if (b_req) begin
            grant_b = 1'b1;
        end
    end

    assign g_op    = grant_b ? b_op    : a_op;
    assign g_addr  = grant_b ? b_addr  : a_addr;
    assign g_wdata = grant_b ? b_wdata : a_wdata;

    assign a_stall = a_req & ~a_ack;
    assign b_stall = b_req & ~b_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_lat     <= OP_READ;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            busy       <= 1'b0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_push   <= 1'b0;
            mem_pop    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        sel        <= grant_b;
                        last_grant <= grant_b;
                        op_lat     <= g_op;
                        mem_addr   <= g_addr;
                        mem_wdata  <= g_wdata;
                        mem_read   <= (g_op == OP_READ);
                        mem_write  <= (g_op == OP_WRITE);
                        mem_push   <= (g_op == OP_PUSH);
                        mem_pop    <= (g_op == OP_POP);
                        busy       <= 1'b1;
                        state      <= ACC;
                    end
                end
                ACC: begin
                    // RAM answers combinationally, so capture at the closing edge of the strobe cycle.
                    if (op_lat == OP_READ || op_lat == OP_POP) begin
                        if (sel) begin
                            b_rdata <= mem_rdata;
                        end else begin
                            a_rdata <= mem_rdata;
                        end
                    end
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    mem_push  <= 1'b0;
                    mem_pop   <= 1'b0;
                    a_ack     <= ~sel;
                    b_ack     <= sel;
                    state     <= ACK;
                end
                ACK: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    a_ack     <= 1'b0;
                    b_ack     <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    mem_push  <= 1'b0;
                    mem_pop   <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each with its own RAM + stack model; randomized traffic checked against a queue model.
module tb_mem_port_arbiter;

    logic       clk;
    logic       rst;
    logic       a_req, b_req;
    logic [1:0] a_op, b_op;
    logic [7:0] a_addr, b_addr, a_wdata, b_wdata;

    logic       a_ack0, b_ack0, a_stall0, b_stall0, busy0;
    logic       mem_read0, mem_write0, mem_push0, mem_pop0;
    logic [7:0] a_rdata0, b_rdata0, mem_addr0, mem_wdata0, mem_rdata0;

    logic       a_ack1, b_ack1, a_stall1, b_stall1, busy1;
    logic       mem_read1, mem_write1, mem_push1, mem_pop1;
    logic [7:0] a_rdata1, b_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.DATA_W(8), .ADDR_W(8), .PRIO_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack0), .a_rdata(a_rdata0), .a_stall(a_stall0),
        .b_req(b_req), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack0), .b_rdata(b_rdata0), .b_stall(b_stall0),
        .mem_read(mem_read0), .mem_write(mem_write0), .mem_push(mem_push0), .mem_pop(mem_pop0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .busy(busy0)
    );

    mem_port_arbiter #(.DATA_W(8), .ADDR_W(8), .PRIO_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack1), .a_rdata(a_rdata1), .a_stall(a_stall1),
        .b_req(b_req), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack1), .b_rdata(b_rdata1), .b_stall(b_stall1),
        .mem_read(mem_read1), .mem_write(mem_write1), .mem_push(mem_push1), .mem_pop(mem_pop1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM + stack behind each instance; contents reload to i^0x4A on reset
    logic [7:0] ram0 [256];
    logic [7:0] stk0 [32];
    logic [4:0] sp0;
    logic [7:0] ram1 [256];
    logic [7:0] stk1 [32];
    logic [4:0] sp1;

    always_comb mem_rdata0 = mem_pop0 ? ((sp0 != 5'd0) ? stk0[sp0 - 5'd1] : 8'h00) : ram0[mem_addr0];
    always_comb mem_rdata1 = mem_pop1 ? ((sp1 != 5'd0) ? stk1[sp1 - 5'd1] : 8'h00) : ram1[mem_addr1];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram0[i] <= 8'(i) ^ 8'h4A;
            sp0 <= 5'd0;
        end else begin
            if (mem_write0) ram0[mem_addr0] <= mem_wdata0;
            if (mem_push0 && sp0 != 5'd31) begin
                stk0[sp0] <= mem_wdata0;
                sp0 <= sp0 + 5'd1;
            end
            if (mem_pop0 && sp0 != 5'd0) sp0 <= sp0 - 5'd1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram1[i] <= 8'(i) ^ 8'h4A;
            sp1 <= 5'd0;
        end else begin
            if (mem_write1) ram1[mem_addr1] <= mem_wdata1;
            if (mem_push1 && sp1 != 5'd31) begin
                stk1[sp1] <= mem_wdata1;
                sp1 <= sp1 + 5'd1;
            end
            if (mem_pop1 && sp1 != 5'd0) sp1 <= sp1 - 5'd1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
        a_op = 2'd0; b_op = 2'd0; a_addr = 8'd0; b_addr = 8'd0; a_wdata = 8'd0; b_wdata = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({mem_read0, mem_write0, mem_push0, mem_pop0, a_ack0, b_ack0, busy0, a_stall0, b_stall0} !== 9'd0) begin
                errors++;
                $display("FAIL reset_ctrl cycle %0d: rd/wr/pu/po/aack/back/busy/ast/bst=%b required 000000000", c,
                         {mem_read0, mem_write0, mem_push0, mem_pop0, a_ack0, b_ack0, busy0, a_stall0, b_stall0});
            end
            checks++;
            if ({mem_addr0, mem_wdata0, a_rdata0, b_rdata0, a_rdata1, b_rdata1, busy1} !== 33'd0) begin
                errors++;
                $display("FAIL reset_data cycle %0d: addr=%h wdata=%h ard=%h brd=%h busy1=%b required all 0", c,
                         mem_addr0, mem_wdata0, a_rdata0, b_rdata0, busy1);
            end
        end
    endtask

    task automatic test_read();
        a_op = 2'd0; a_addr = 8'h10; a_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_read0, mem_write0, mem_push0, mem_pop0} !== 4'b1000 || mem_addr0 !== 8'h10 || a_stall0 !== 1'b1) begin
            errors++;
            $display("FAIL read_strobe: strobes=%b addr=%h stall=%b required 1000 10 1",
                     {mem_read0, mem_write0, mem_push0, mem_pop0}, mem_addr0, a_stall0);
        end
        @(negedge clk);
        checks++;
        if (a_ack0 !== 1'b1 || a_rdata0 !== 8'h5A || mem_read0 !== 1'b0 || a_stall0 !== 1'b0) begin
            errors++;
            $display("FAIL read_ack: ack=%b rdata=%h rd=%b stall=%b required 1 5a 0 0", a_ack0, a_rdata0, mem_read0, a_stall0);
        end
        a_req = 1'b0;
        @(negedge clk);
        checks++;
        if (a_ack0 !== 1'b0 || busy0 !== 1'b0 || a_rdata0 !== 8'h5A) begin
            errors++;
            $display("FAIL read_after: ack=%b busy=%b rdata=%h required 0 0 5a", a_ack0, busy0, a_rdata0);
        end
    endtask

    task automatic test_round_robin();
        int n;
        logic exp_b;
        apply_reset();
        a_op = 2'd1; a_addr = 8'h20; a_wdata = 8'h11; a_req = 1'b1;
        b_op = 2'd0; b_addr = 8'h20; b_req = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_write0 !== 1'b1 || mem_addr0 !== 8'h20 || mem_wdata0 !== 8'h11 || b_stall0 !== 1'b1) begin
            errors++;
            $display("FAIL rr_first_write: wr=%b addr=%h wdata=%h bstall=%b required 1 20 11 1",
                     mem_write0, mem_addr0, mem_wdata0, b_stall0);
        end
        @(negedge clk);
        checks++;
        if (a_ack0 !== 1'b1 || b_ack0 !== 1'b0) begin
            errors++;
            $display("FAIL rr_first_ack: a_ack=%b b_ack=%b required 1 0", a_ack0, b_ack0);
        end
        a_op = 2'd0;
        exp_b = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(a_ack0 || b_ack0) && n < 8);
            checks++;
            if (n !== 3 || b_ack0 !== exp_b || a_ack0 !== !exp_b) begin
                errors++;
                $display("FAIL rr_alternate %0d: latency=%0d a_ack=%b b_ack=%b required 3 and b_ack=%b", k, n, a_ack0, b_ack0, exp_b);
            end
            checks++;
            if ((exp_b ? b_rdata0 : a_rdata0) !== 8'h11) begin
                errors++;
                $display("FAIL rr_rdata %0d: got %h required 11", k, exp_b ? b_rdata0 : a_rdata0);
            end
            exp_b = !exp_b;
        end
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        int n;
        apply_reset();
        a_op = 2'd0; a_addr = 8'h01; a_req = 1'b1;
        b_op = 2'd0; b_addr = 8'h02; b_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(a_ack1 || b_ack1) && n < 8);
            checks++;
            if (a_ack1 !== 1'b1 || b_ack1 !== 1'b0 || a_rdata1 !== 8'h4B) begin
                errors++;
                $display("FAIL prio_a_wins %0d: a_ack=%b b_ack=%b a_rdata=%h required 1 0 4b", k, a_ack1, b_ack1, a_rdata1);
            end
        end
        a_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(a_ack1 || b_ack1) && n < 8);
        checks++;
        if (n !== 3 || b_ack1 !== 1'b1 || a_ack1 !== 1'b0 || b_rdata1 !== 8'h48) begin
            errors++;
            $display("FAIL prio_b_after: latency=%0d b_ack=%b a_ack=%b b_rdata=%h required 3 1 0 48", n, b_ack1, a_ack1, b_rdata1);
        end
        b_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_push_pop();
        int n, cyc, push_at, pop_at, pushes, pops, bad;
        apply_reset();
        cyc = 0; push_at = -1; pop_at = -1; pushes = 0; pops = 0; bad = 0;
        b_op = 2'd2; b_wdata = 8'h33; b_addr = 8'h00; b_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++; cyc++;
                if (mem_read0 || mem_write0) bad++;
                if (mem_push0) begin pushes++; push_at = cyc; end
                if (mem_pop0) begin pops++; pop_at = cyc; end
            end while (!b_ack0 && n < 8);
            checks++;
            if (b_ack0 !== 1'b1 || b_rdata0 !== (k == 0 ? 8'h00 : 8'h33)) begin
                errors++;
                $display("FAIL pushpop_ack %0d: b_ack=%b b_rdata=%h required 1 %h", k, b_ack0, b_rdata0, (k == 0 ? 8'h00 : 8'h33));
            end
            b_op = 2'd3;
        end
        b_req = 1'b0;
        @(negedge clk);
        checks++;
        if (pushes !== 1 || pops !== 1 || bad !== 0 || !(push_at < pop_at)) begin
            errors++;
            $display("FAIL pushpop_strobes: pushes=%0d pops=%0d rd_wr=%0d push_at=%0d pop_at=%0d required 1 1 0 push first",
                     pushes, pops, bad, push_at, pop_at);
        end
    endtask

    task automatic test_random();
        logic [7:0] mram [256];
        logic [7:0] mstk [$];
        logic       mlast;
        logic [7:0] exp_ard, exp_brd, exp_r;
        logic [1:0] rop [2];
        logic [7:0] raddr [2];
        logic [7:0] rwd [2];
        bit         en [2];
        int         ord [2];
        int         cnt, depth, n, p, o;
        apply_reset();
        for (int i = 0; i < 256; i++) mram[i] = 8'(i) ^ 8'h4A;
        mstk.delete();
        mlast = 1'b1;
        exp_ard = 8'h00; exp_brd = 8'h00;
        for (int r = 0; r < 40; r++) begin
            en[0] = 1'($urandom_range(0, 1));
            en[1] = 1'($urandom_range(0, 1));
            if (!en[0] && !en[1]) en[0] = 1'b1;
            if (en[0] && en[1]) begin
                ord[0] = mlast ? 0 : 1;
                ord[1] = 1 - ord[0];
                cnt = 2;
            end else begin
                ord[0] = en[1] ? 1 : 0;
                ord[1] = 0;
                cnt = 1;
            end
            depth = mstk.size();
            for (int s = 0; s < cnt; s++) begin
                p = ord[s];
                o = int'($urandom_range(0, 3));
                if (o == 3 && depth == 0) o = 0;
                if (o == 2 && depth >= 16) o = 1;
                if (o == 2) depth++;
                if (o == 3) depth--;
                rop[p] = 2'(o);
                raddr[p] = 8'($urandom_range(0, 15));
                rwd[p] = 8'($urandom);
            end
            a_op = rop[0]; a_addr = raddr[0]; a_wdata = rwd[0]; a_req = en[0];
            b_op = rop[1]; b_addr = raddr[1]; b_wdata = rwd[1]; b_req = en[1];
            for (int s = 0; s < cnt; s++) begin
                p = ord[s];
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                    checks++;
                    if (a_ack0 && b_ack0) begin
                        errors++;
                        $display("FAIL rand_dual_ack round %0d: a_ack and b_ack both 1, required at most one", r);
                    end
                end while (!(a_ack0 || b_ack0) && n < 8);
                checks++;
                if (n !== (s == 0 ? 2 : 3) || a_ack0 !== (p == 0) || b_ack0 !== (p == 1)) begin
                    errors++;
                    $display("FAIL rand_grant round %0d slot %0d: latency=%0d a_ack=%b b_ack=%b required %0d port %s",
                             r, s, n, a_ack0, b_ack0, (s == 0 ? 2 : 3), (p == 0) ? "A" : "B");
                end
                exp_r = 8'h00;
                case (rop[p])
                    2'd0: exp_r = mram[raddr[p]];
                    2'd1: mram[raddr[p]] = rwd[p];
                    2'd2: mstk.push_back(rwd[p]);
                    default: exp_r = mstk.pop_back();
                endcase
                if (rop[p] == 2'd0 || rop[p] == 2'd3) begin
                    if (p == 0) exp_ard = exp_r; else exp_brd = exp_r;
                end
                checks++;
                if (a_rdata0 !== exp_ard || b_rdata0 !== exp_brd) begin
                    errors++;
                    $display("FAIL rand_rdata round %0d op %0d port %0d: a_rdata=%h b_rdata=%h required %h %h",
                             r, rop[p], p, a_rdata0, b_rdata0, exp_ard, exp_brd);
                end
                if (p == 0) a_req = 1'b0; else b_req = 1'b0;
                mlast = (p == 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_access();
        a_op = 2'd1; a_addr = 8'h30; a_wdata = 8'h77; a_req = 1'b1; b_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_write0 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_acc: mem_write=%b required 1", mem_write0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a_req = 1'b0;
        checks++;
        if ({mem_read0, mem_write0, mem_push0, mem_pop0, a_ack0, b_ack0, busy0} !== 7'd0) begin
            errors++;
            $display("FAIL rstmid_clear: rd/wr/pu/po/aack/back/busy=%b required 0000000",
                     {mem_read0, mem_write0, mem_push0, mem_pop0, a_ack0, b_ack0, busy0});
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (a_ack0 !== 1'b0 || b_ack0 !== 1'b0 || busy0 !== 1'b0 || mem_write0 !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_no_ack cycle %0d: a_ack=%b b_ack=%b busy=%b wr=%b required 0 0 0 0",
                         c, a_ack0, b_ack0, busy0, mem_write0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_round_robin();
        test_fixed_priority();
        test_push_pop();
        test_random();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
